// File: rtl/ipacket_decode_queue.sv
// Fetch-to-decode queue for LC-3b: decodes instructions on entry, buffers them in a
// circular FIFO, and can issue LDI/STI as two micro-ops from the head entry.

package ipacket_decode_queue_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_X    = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       br_pred;
        logic       indirect;
    } ctrl_t;

endpackage

module ipacket_decode_queue
    import ipacket_decode_queue_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned SPLIT_INDIRECT = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_inst,
    input  logic [WIDTH-1:0]             in_pc,
    input  logic                         in_br_pred,
    input  logic [WIDTH-1:0]             in_target_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_inst,
    output logic [WIDTH-1:0]             out_pc,
    output logic [WIDTH-1:0]             out_target_pc,
    output logic [3:0]                   out_opcode,
    output logic [2:0]                   out_dr,
    output logic [2:0]                   out_sr1,
    output logic [2:0]                   out_sr2,
    output logic                         out_load_regfile,
    output logic                         out_load_cc,
    output logic                         out_mem_read,
    output logic                         out_mem_write,
    output logic                         out_branch,
    output logic                         out_jump,
    output logic                         out_br_pred,
    output logic                         out_uop,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef enum logic {FIRST, SECOND} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     head, tail;
    logic [WIDTH-1:0]  inst_q [DEPTH];
    logic [WIDTH-1:0]  pc_q   [DEPTH];
    logic [WIDTH-1:0]  tgt_q  [DEPTH];
    ctrl_t             ctrl_q [DEPTH];
    ctrl_t             head_ctrl;
    logic              push, pop, handshake, split_head;

    // Control-field decode performed once, as the instruction enters the queue.
    function automatic ctrl_t decode(input logic [WIDTH-1:0] inst, input logic bp);
        ctrl_t c;
        c         = '0;
        c.opcode  = inst[15:12];
        c.dr      = inst[11:9];
        c.sr1     = inst[8:6];
        c.sr2     = inst[2:0];
        c.br_pred = bp;
        case (c.opcode)
            OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_X: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
            end
            OP_LDB, OP_LDR: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.mem_read     = 1'b1;
            end
            OP_LDI: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.mem_read     = 1'b1;
                c.indirect     = 1'b1;
            end
            OP_STB, OP_STR: c.mem_write = 1'b1;
            OP_STI: begin
                c.mem_write = 1'b1;
                c.indirect  = 1'b1;
            end
            OP_JSR: begin
                c.load_regfile = 1'b1;
                c.jump         = 1'b1;
                c.dr           = 3'd7;
            end
            OP_TRAP: begin
                c.load_regfile = 1'b1;
                c.mem_read     = 1'b1;
                c.jump         = 1'b1;
                c.dr           = 3'd7;
            end
            OP_JMP:  c.jump   = 1'b1;
            OP_BR:   c.branch = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign in_ready   = (count != CW'(DEPTH)) && !flush;
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign head_ctrl  = ctrl_q[head];
    assign split_head = (SPLIT_INDIRECT != 0) && head_ctrl.indirect;
    assign pop        = handshake && !flush && (!split_head || (state == SECOND));

    // Entry payload storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= in_inst;
            pc_q[tail]   <= in_pc + WIDTH'(2);
            tgt_q[tail]  <= in_target_pc;
            ctrl_q[tail] <= decode(in_inst, in_br_pred);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FIRST;
        else          state <= state_n;
    end

    // Head micro-op sequencing: indirect entries stay at the head for two accepted beats.
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = FIRST;
        end else if (handshake && split_head) begin
            state_n = (state == FIRST) ? SECOND : FIRST;
        end
    end

    always_comb begin
        out_inst         = '0;
        out_pc           = '0;
        out_target_pc    = '0;
        out_opcode       = '0;
        out_dr           = '0;
        out_sr1          = '0;
        out_sr2          = '0;
        out_load_regfile = 1'b0;
        out_load_cc      = 1'b0;
        out_mem_read     = 1'b0;
        out_mem_write    = 1'b0;
        out_branch       = 1'b0;
        out_jump         = 1'b0;
        out_br_pred      = 1'b0;
        out_uop          = 1'b0;
        if (out_valid) begin
            out_inst         = inst_q[head];
            out_pc           = pc_q[head];
            out_target_pc    = tgt_q[head];
            out_opcode       = head_ctrl.opcode;
            out_dr           = head_ctrl.dr;
            out_sr1          = head_ctrl.sr1;
            out_sr2          = head_ctrl.sr2;
            out_load_regfile = head_ctrl.load_regfile;
            out_load_cc      = head_ctrl.load_cc;
            out_mem_read     = head_ctrl.mem_read;
            out_mem_write    = head_ctrl.mem_write;
            out_branch       = head_ctrl.branch;
            out_jump         = head_ctrl.jump;
            out_br_pred      = head_ctrl.br_pred;
            out_uop          = split_head && (state == SECOND);
            // First beat of a split access only fetches the indirect pointer.
            if (split_head && (state == FIRST)) begin
                out_load_regfile = 1'b0;
                out_load_cc      = 1'b0;
                out_mem_read     = 1'b1;
                out_mem_write    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ipacket_decode_queue.sv
// Directed bench for ipacket_decode_queue: scoreboard of expected uop beats plus
// point checks on handshake, occupancy, split sequencing, flush and reset.

module tb_ipacket_decode_queue;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic [3:0]  op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic        lr;
        logic        lc;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jmp;
        logic        bp;
        logic        uop;
    } beat_t;

    logic        clk, reset_n, flush;
    logic        in_valid, in_br_pred, out_ready;
    logic [15:0] in_inst, in_pc, in_target_pc;
    logic        in_ready, out_valid;
    logic [15:0] out_inst, out_pc, out_target_pc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dr, out_sr1, out_sr2;
    logic        out_load_regfile, out_load_cc, out_mem_read, out_mem_write;
    logic        out_branch, out_jump, out_br_pred, out_uop;
    logic [2:0]  count;

    logic        in_valid0, out_ready0, n_in_ready, n_out_valid;
    logic [15:0] n_inst, n_pc, n_tgt;
    logic [3:0]  n_op;
    logic [2:0]  n_dr, n_sr1, n_sr2;
    logic        n_lr, n_lc, n_mr, n_mw, n_br, n_jmp, n_bp, n_uop;
    logic [2:0]  n_count;

    int    vectors;
    int    miscompares;
    beat_t sb[$];

    ipacket_decode_queue #(.WIDTH(16), .DEPTH(4), .SPLIT_INDIRECT(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_br_pred(in_br_pred), .in_target_pc(in_target_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_target_pc(out_target_pc), .out_opcode(out_opcode), .out_dr(out_dr),
        .out_sr1(out_sr1), .out_sr2(out_sr2), .out_load_regfile(out_load_regfile),
        .out_load_cc(out_load_cc), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_br_pred(out_br_pred),
        .out_uop(out_uop), .count(count)
    );

    ipacket_decode_queue #(.WIDTH(16), .DEPTH(4), .SPLIT_INDIRECT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid0), .in_ready(n_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_br_pred(in_br_pred), .in_target_pc(in_target_pc),
        .out_valid(n_out_valid), .out_ready(out_ready0), .out_inst(n_inst), .out_pc(n_pc),
        .out_target_pc(n_tgt), .out_opcode(n_op), .out_dr(n_dr),
        .out_sr1(n_sr1), .out_sr2(n_sr2), .out_load_regfile(n_lr),
        .out_load_cc(n_lc), .out_mem_read(n_mr), .out_mem_write(n_mw),
        .out_branch(n_br), .out_jump(n_jmp), .out_br_pred(n_bp),
        .out_uop(n_uop), .count(n_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference decode of one instruction into its single (unsplit) beat.
    function automatic beat_t model(input logic [15:0] inst, input logic [15:0] pc,
                                    input logic [15:0] tgt, input logic bp);
        beat_t      b;
        logic [3:0] op;
        op    = inst[15:12];
        b.inst = inst;
        b.pc   = pc + 16'd2;
        b.tgt  = tgt;
        b.op   = op;
        b.dr   = (op == 4'h4 || op == 4'hF) ? 3'd7 : inst[11:9];
        b.sr1  = inst[8:6];
        b.sr2  = inst[2:0];
        b.lr   = op inside {4'h1, 4'h5, 4'h9, 4'hD, 4'h2, 4'h6, 4'hA, 4'hE, 4'h4, 4'hF, 4'h8};
        b.lc   = op inside {4'h1, 4'h5, 4'h9, 4'hD, 4'h2, 4'h6, 4'hA, 4'hE, 4'h8};
        b.mr   = op inside {4'h2, 4'h6, 4'hA, 4'hF};
        b.mw   = op inside {4'h3, 4'h7, 4'hB};
        b.br   = (op == 4'h0);
        b.jmp  = op inside {4'hC, 4'h4, 4'hF};
        b.bp   = bp;
        b.uop  = 1'b0;
        return b;
    endfunction

    task automatic push_expected(input logic [15:0] inst, input logic [15:0] pc,
                                 input logic [15:0] tgt, input logic bp);
        beat_t b, f;
        b = model(inst, pc, tgt, bp);
        if (b.op == 4'hA || b.op == 4'hB) begin
            f     = b;
            f.lr  = 1'b0;
            f.lc  = 1'b0;
            f.mr  = 1'b1;
            f.mw  = 1'b0;
            sb.push_back(f);
            b.uop = 1'b1;
        end
        sb.push_back(b);
    endtask

    function automatic beat_t obs();
        beat_t b;
        b.inst = out_inst;        b.pc  = out_pc;          b.tgt = out_target_pc;
        b.op   = out_opcode;      b.dr  = out_dr;          b.sr1 = out_sr1;
        b.sr2  = out_sr2;         b.lr  = out_load_regfile; b.lc = out_load_cc;
        b.mr   = out_mem_read;    b.mw  = out_mem_write;   b.br  = out_branch;
        b.jmp  = out_jump;        b.bp  = out_br_pred;     b.uop = out_uop;
        return b;
    endfunction

    // One clock: score any downstream handshake, log any accepted enqueue, advance.
    task automatic tick();
        beat_t e;
        logic  f;
        #2;
        f = flush;
        if (out_valid && out_ready) begin
            chk("sb_avail", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat", 128'(obs()), 128'(e));
            end
        end
        if (in_valid && in_ready) push_expected(in_inst, in_pc, in_target_pc, in_br_pred);
        @(posedge clk);
        #1;
        if (f) sb.delete();
    endtask

    task automatic drive(input logic [15:0] inst, input logic [15:0] pc,
                         input logic [15:0] tgt, input logic bp);
        in_valid     = 1'b1;
        in_inst      = inst;
        in_pc        = pc;
        in_target_pc = tgt;
        in_br_pred   = bp;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", 128'(out_valid), 128'(0));
        chk("sb_left", 128'(sb.size()), 128'(0));
    endtask

    logic [15:0] mix [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_target_pc = '0; in_br_pred = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        mix[0] = 16'h1263; mix[1] = 16'h4801; mix[2] = 16'h0E05; mix[3] = 16'h5A7F;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_fields", 128'(obs()), 128'(0));
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Reset while three entries are queued.
        for (int i = 0; i < 3; i++) begin
            drive(16'h1263, 16'h3000 + 16'(2 * i), 16'h4000, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count3", 128'(count), 128'(3));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_fields", 128'(obs()), 128'(0));
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fill to DEPTH, confirm no full-bypass, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(16'h1263, 16'h3000 + 16'(2 * i), 16'h4000, 1'b0);
            tick();
        end
        drive(16'h5A7F, 16'h3008, 16'h4000, 1'b0);
        #1;
        chk("full_count", 128'(count), 128'(4));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_head_dr", 128'(out_dr), 128'(1));
        out_ready = 1'b1;
        #1;
        chk("full_deq_in_ready", 128'(in_ready), 128'(0));
        tick();
        chk("full_after_pop", 128'(count), 128'(3));
        drain();

        // LDI split into two beats; SPLIT_INDIRECT=0 instance issues one beat.
        drive(16'hA5C3, 16'h3000, 16'h0000, 1'b0);
        in_valid0 = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        chk("ldi_b0_uop", 128'(out_uop), 128'(0));
        chk("ldi_b0_mr", 128'(out_mem_read), 128'(1));
        chk("ldi_b0_lr", 128'(out_load_regfile), 128'(0));
        chk("ldi_b0_lc", 128'(out_load_cc), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ldi_hold_uop", 128'(out_uop), 128'(0));
            chk("ldi_hold_pc", 128'(out_pc), 128'(16'h3002));
            chk("ldi_hold_lr", 128'(out_load_regfile), 128'(0));
        end
        chk("nos_uop", 128'(n_uop), 128'(0));
        chk("nos_lr", 128'(n_lr), 128'(1));
        chk("nos_lc", 128'(n_lc), 128'(1));
        out_ready  = 1'b1;
        out_ready0 = 1'b1;
        tick();
        out_ready  = 1'b0;
        out_ready0 = 1'b0;
        chk("nos_count", 128'(n_count), 128'(0));
        chk("ldi_b1_uop", 128'(out_uop), 128'(1));
        chk("ldi_b1_lr", 128'(out_load_regfile), 128'(1));
        chk("ldi_b1_lc", 128'(out_load_cc), 128'(1));
        chk("ldi_b1_dr", 128'(out_dr), 128'(2));
        chk("ldi_b1_pc", 128'(out_pc), 128'(16'h3002));
        chk("ldi_b1_count", 128'(count), 128'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ldi_done_count", 128'(count), 128'(0));

        // Flush while STI is on its second beat with two more entries behind it.
        drive(16'hB7C0, 16'h3100, 16'h0000, 1'b0); tick();
        drive(16'h1263, 16'h3102, 16'h0000, 1'b0); tick();
        drive(16'h1263, 16'h3104, 16'h0000, 1'b0); tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sti_b1_uop", 128'(out_uop), 128'(1));
        chk("sti_b1_mw", 128'(out_mem_write), 128'(1));
        chk("sti_b1_mr", 128'(out_mem_read), 128'(0));
        chk("sti_b1_count", 128'(count), 128'(3));
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(16'h1263, 16'h3106, 16'h0000, 1'b0);
        #1;
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        drive(16'hB7C0, 16'h3200, 16'h0000, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("post_flush_uop", 128'(out_uop), 128'(0));
        chk("post_flush_mr", 128'(out_mem_read), 128'(1));
        chk("post_flush_mw", 128'(out_mem_write), 128'(0));
        drain();

        // JSR and predicted-taken BR decode.
        drive(16'h4801, 16'h3300, 16'h3400, 1'b0); tick();
        drive(16'h0E05, 16'h3302, 16'h3310, 1'b1); tick();
        in_valid = 1'b0;
        chk("jsr_dr", 128'(out_dr), 128'(7));
        chk("jsr_lr", 128'(out_load_regfile), 128'(1));
        chk("jsr_jump", 128'(out_jump), 128'(1));
        chk("jsr_lc", 128'(out_load_cc), 128'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("br_branch", 128'(out_branch), 128'(1));
        chk("br_pred", 128'(out_br_pred), 128'(1));
        chk("br_target", 128'(out_target_pc), 128'(16'h3310));
        drain();

        // Steady state: simultaneous enqueue and dequeue with pointer wrap.
        drive(16'h1263, 16'h5000, 16'h6000, 1'b0); tick();
        drive(16'h4801, 16'h5002, 16'h6002, 1'b0); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(mix[i % 4], 16'h5004 + 16'(2 * i), 16'h6100 + 16'(i), 1'(i % 2));
            tick();
            chk("steady_count", 128'(count), 128'(2));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
